// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        StInit,
        StRun,
        StLoadStall,
        StMemWait,
        StRedirect
    } state_e;

    localparam int unsigned RegIdxW   = 5;
    localparam int unsigned StallCntW = 32;
    localparam int unsigned FlushCntW = 16;

    // ADDI x0, x0, 0 -- what a flushed stage register carries downstream.
    localparam logic [31:0] NopInsn = 32'h0000_0013;

    typedef struct packed {
        logic if_stall;
        logic id_stall;
        logic ex_stall;
        logic mem_stall;
        logic id_flush;
        logic ex_flush;
        logic pc_redirect_sel;
    } ctrl_t;

    localparam ctrl_t CtrlNone = '{default: 1'b0};

    localparam ctrl_t CtrlInit = '{
        if_stall: 1'b0, id_stall: 1'b0, ex_stall: 1'b0, mem_stall: 1'b0,
        id_flush: 1'b1, ex_flush: 1'b1, pc_redirect_sel: 1'b0
    };

    localparam ctrl_t CtrlMemWait = '{
        if_stall: 1'b1, id_stall: 1'b1, ex_stall: 1'b1, mem_stall: 1'b1,
        id_flush: 1'b0, ex_flush: 1'b0, pc_redirect_sel: 1'b0
    };

    localparam ctrl_t CtrlRedirect = '{
        if_stall: 1'b0, id_stall: 1'b0, ex_stall: 1'b0, mem_stall: 1'b0,
        id_flush: 1'b1, ex_flush: 1'b1, pc_redirect_sel: 1'b1
    };

    localparam ctrl_t CtrlSquash = '{
        if_stall: 1'b0, id_stall: 1'b0, ex_stall: 1'b0, mem_stall: 1'b0,
        id_flush: 1'b1, ex_flush: 1'b0, pc_redirect_sel: 1'b0
    };

    localparam ctrl_t CtrlLoadUse = '{
        if_stall: 1'b1, id_stall: 1'b1, ex_stall: 1'b0, mem_stall: 1'b0,
        id_flush: 1'b0, ex_flush: 1'b1, pc_redirect_sel: 1'b0
    };

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: decode reads a register the load in execute is about to write.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic               ex_mem_read_i,
    input  logic [RegIdxW-1:0] ex_rd_i,
    input  logic [RegIdxW-1:0] id_rs1_i,
    input  logic [RegIdxW-1:0] id_rs2_i,
    input  logic               id_uses_rs1_i,
    input  logic               id_uses_rs2_i,
    output logic               hit_o
);

    logic rd_nonzero;
    logic rs1_match;
    logic rs2_match;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign rd_nonzero = (ex_rd_i != '0);
    assign rs1_match  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_match  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    assign hit_o      = ex_mem_read_i && rd_nonzero && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect controller for a 5-stage in-order pipeline.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [RegIdxW-1:0]   id_rs1,
    input  logic [RegIdxW-1:0]   id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [RegIdxW-1:0]   ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_redirect,
    input  logic                 dmem_req,
    input  logic                 dmem_ack,
    output logic                 if_stall,
    output logic                 id_stall,
    output logic                 ex_stall,
    output logic                 mem_stall,
    output logic                 id_flush,
    output logic                 ex_flush,
    output logic                 pc_redirect_sel,
    output logic [StallCntW-1:0] stall_cycles,
    output logic [FlushCntW-1:0] flush_events
);

    state_e               state_q, state_d;
    ctrl_t                ctrl;
    logic                 load_use;
    logic                 mem_wait;
    logic                 enter_redirect;
    logic [StallCntW-1:0] stall_cnt_q, stall_cnt_d;
    logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;

    hazard_detect u_hazard_detect (
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .hit_o         (load_use)
    );

    assign mem_wait = dmem_req && !dmem_ack;

    // Outputs respond in the same cycle; only the state is registered.
    always_comb begin
        ctrl    = CtrlNone;
        state_d = state_q;
        unique case (state_q)
            StInit: begin
                ctrl    = CtrlInit;
                state_d = StRun;
            end
            StRun: begin
                if (mem_wait) begin
                    ctrl    = CtrlMemWait;
                    state_d = StMemWait;
                end else if (ex_redirect) begin
                    ctrl    = CtrlRedirect;
                    state_d = StRedirect;
                end else if (load_use) begin
                    ctrl    = CtrlLoadUse;
                    state_d = StLoadStall;
                end
            end
            StLoadStall: begin
                if (mem_wait) begin
                    ctrl    = CtrlMemWait;
                    state_d = StMemWait;
                end else begin
                    state_d = StRun;
                end
            end
            StMemWait: begin
                if (!dmem_ack) begin
                    ctrl = CtrlMemWait;
                end else begin
                    state_d = StRun;
                end
            end
            StRedirect: begin
                // Redirect still held by execute is ignored here; the squash is one cycle.
                if (mem_wait) begin
                    ctrl    = CtrlMemWait;
                    state_d = StMemWait;
                end else begin
                    ctrl    = CtrlSquash;
                    state_d = StRun;
                end
            end
            default: begin
                ctrl    = CtrlInit;
                state_d = StInit;
            end
        endcase
    end

    assign enter_redirect = (state_d == StRedirect) && (state_q != StRedirect);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ctrl.if_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + StallCntW'(1);
        end
        if (enter_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + FlushCntW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StInit;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign if_stall        = ctrl.if_stall;
    assign id_stall        = ctrl.id_stall;
    assign ex_stall        = ctrl.ex_stall;
    assign mem_stall       = ctrl.mem_stall;
    assign id_flush        = ctrl.id_flush;
    assign ex_flush        = ctrl.ex_flush;
    assign pc_redirect_sel = ctrl.pc_redirect_sel;
    assign stall_cycles    = stall_cnt_q;
    assign flush_events    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench with an expected-output scoreboard for pipeline_ctrl.
module tb_pipeline_ctrl;

    // Expected output vector: {if, id, ex, mem stall, id_flush, ex_flush, pc_redirect_sel}
    localparam logic [6:0] ONone   = 7'b0000000;
    localparam logic [6:0] OInit   = 7'b0000110;
    localparam logic [6:0] OLoad   = 7'b1100010;
    localparam logic [6:0] OMem    = 7'b1111000;
    localparam logic [6:0] ORedir  = 7'b0000111;
    localparam logic [6:0] OSquash = 7'b0000100;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       req;
        logic       ack;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] exp;
    } sb_t;

    logic        clk;
    logic        resetn;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, dmem_req, dmem_ack;
    logic        if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, pc_redirect_sel;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;

    sb_t         sb_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned exp_stall_cnt = 0;
    int unsigned exp_flush_cnt = 0;
    vec_t        tbl[14];
    vec_t        idle;

    pipeline_ctrl dut (
        .clk             (clk),
        .resetn          (resetn),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_redirect     (ex_redirect),
        .dmem_req        (dmem_req),
        .dmem_ack        (dmem_ack),
        .if_stall        (if_stall),
        .id_stall        (id_stall),
        .ex_stall        (ex_stall),
        .mem_stall       (mem_stall),
        .id_flush        (id_flush),
        .ex_flush        (ex_flush),
        .pc_redirect_sel (pc_redirect_sel),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic mr, input logic redir, input logic req,
                                input logic ack, input logic [6:0] e);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.mr = mr; v.redir = redir; v.req = req; v.ack = ack; v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_uses_rs1 = v.u1;
        id_uses_rs2 = v.u2;
        ex_rd       = v.rd;
        ex_mem_read = v.mr;
        ex_redirect = v.redir;
        dmem_req    = v.req;
        dmem_ack    = v.ack;
    endtask

    task automatic compare_out();
        sb_t        e;
        logic [6:0] act;
        e   = sb_q.pop_front();
        act = {if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, pc_redirect_sel};
        total++;
        if (act !== e.exp) begin
            bad++;
            $display("FAIL %s: outputs got %b want %b", e.name, act, e.exp);
        end
    endtask

    task automatic expect_now(input string n, input logic [6:0] e);
        sb_t s;
        s.name = n;
        s.exp  = e;
        sb_q.push_back(s);
        compare_out();
    endtask

    // One clock cycle: drive after the edge, check at the falling edge, then advance the model.
    task automatic step(input vec_t v);
        sb_t s;
        @(posedge clk);
        #1;
        drive(v);
        s.name = v.name;
        s.exp  = v.exp;
        sb_q.push_back(s);
        @(negedge clk);
        compare_out();
        if (v.exp[6]) exp_stall_cnt++;
        if (v.exp[0]) exp_flush_cnt++;
    endtask

    task automatic check_cnt(input string n);
        total++;
        if (stall_cycles !== exp_stall_cnt) begin
            bad++;
            $display("FAIL %s stall_cycles: got %0d want %0d", n, stall_cycles, exp_stall_cnt);
        end
        total++;
        if (flush_events !== exp_flush_cnt[15:0]) begin
            bad++;
            $display("FAIL %s flush_events: got %0d want %0d", n, flush_events,
                     exp_flush_cnt[15:0]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        idle    = mk("idle", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, ONone);
        tbl[0]  = mk("run_idle",     5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, ONone);
        tbl[1]  = mk("lu_rs2",       5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, OLoad);
        tbl[2]  = mk("lu_bubble",    5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, ONone);
        tbl[3]  = mk("run_idle2",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, ONone);
        tbl[4]  = mk("lu_x0",        5'd0, 5'd0, 0, 1, 5'd0, 1, 0, 0, 0, ONone);
        tbl[5]  = mk("lu_rs1",       5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, OLoad);
        tbl[6]  = mk("lu_bubble2",   5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, ONone);
        tbl[7]  = mk("rs1_unused",   5'd7, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0, ONone);
        tbl[8]  = mk("not_load",     5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0, ONone);
        tbl[9]  = mk("redir_lu",     5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, ORedir);
        tbl[10] = mk("redir_squash", 5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, OSquash);
        tbl[11] = mk("run_idle3",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, ONone);
        tbl[12] = mk("lu_both",      5'd3, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0, OLoad);
        tbl[13] = mk("lu_bubble3",   5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, ONone);

        resetn = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_now("reset_hold", OInit);
        check_cnt("reset_hold");

        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        expect_now("init_cycle", OInit);

        for (int i = 0; i < 14; i++) step(tbl[i]);
        check_cnt("after_table");

        // Memory wait, ack on the fourth cycle.
        step(mk("mw_c1",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, OMem));
        step(mk("mw_c2",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, OMem));
        step(mk("mw_c3",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, OMem));
        step(mk("mw_ack", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, ONone));
        step(idle);
        check_cnt("mem_wait");

        // Redirect held through a memory wait, taken after the ack.
        step(mk("rm_c1",    5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, OMem));
        step(mk("rm_c2",    5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, OMem));
        step(mk("rm_ack",   5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, ONone));
        step(mk("rm_redir", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, ORedir));
        step(mk("rm_sq",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, OSquash));
        step(idle);
        check_cnt("redir_mem");

        // Memory wait arising in REDIRECT, then in LOAD_STALL.
        step(mk("rd_c1",  5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, ORedir));
        step(mk("rd_mw",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, OMem));
        step(mk("rd_ack", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, ONone));
        step(mk("rd_after", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, ONone));
        step(mk("ls_hit", 5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 0, 0, OLoad));
        step(mk("ls_mw",  5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 1, 0, OMem));
        step(mk("ls_ack", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, ONone));
        step(mk("ls_after", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, ONone));
        step(mk("req_ack_same", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, ONone));
        check_cnt("mw_in_states");

        // Asynchronous reset in the middle of MEM_WAIT.
        step(mk("rst_mw1", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, OMem));
        @(posedge clk);
        #1;
        dmem_req = 1'b1;
        dmem_ack = 1'b0;
        #1;
        expect_now("rst_mw2", OMem);
        #1;
        resetn = 1'b0;
        #1;
        expect_now("rst_async", OInit);
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
        check_cnt("rst_async");
        drive(idle);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        expect_now("init_again", OInit);
        step(idle);
        check_cnt("after_reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 id_rs1, id_rs2  in  5 each  source register indices of the instruction currently in decode.
REQ-004 id_uses_rs1, id_uses_rs2  in  1 each  the decode instruction reads rs1/rs2.
REQ-005 ex_rd  in  5  destination index of the instruction in execute.
REQ-006 ex_mem_read  in  1  the execute instruction is a load.
REQ-007 ex_redirect  in  1  branch taken or jump resolved in execute; held by execute while ex_stall=1.
REQ-008 dmem_req  in  1  memory stage has an access outstanding.
REQ-009 dmem_ack  in  1  memory access completes this cycle.
REQ-010 if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the corresponding stage register.
REQ-011 id_flush, ex_flush  out  1 each  load a NOP (ADDI x0,x0,0; all write/mem/branch/jump enables 0) into the decode/execute output register.
REQ-012 pc_redirect_sel  out  1  fetch selects the execute target PC this cycle.
REQ-013 stall_cycles  out  32  saturating count of cycles with if_stall=1.
REQ-014 flush_events  out  16  saturating count of entries into REDIRECT.

Function
REQ-015 FSM states: INIT, RUN, LOAD_STALL, MEM_WAIT, REDIRECT; outputs are combinational from the state and the current inputs (same-cycle response).
REQ-016 INIT: id_flush=ex_flush=1, all stalls 0; unconditional transition to RUN after exactly one cycle.
REQ-017 Event priority in RUN: mem-wait > redirect > load-use > none.
REQ-018 Mem-wait condition: dmem_req=1 and dmem_ack=0; if_stall=id_stall=ex_stall=mem_stall=1, no flush; next state MEM_WAIT.
REQ-019 MEM_WAIT: all four stalls remain 1 while dmem_ack=0; when dmem_ack=1, stalls deassert in that same cycle and the next state is RUN.
REQ-020 Redirect (ex_redirect=1, no mem-wait): pc_redirect_sel=1, id_flush=1, ex_flush=1, stalls 0; next state REDIRECT; flush_events increments.
REQ-021 REDIRECT: id_flush=1 for exactly one cycle (squashes the wrong-path fetch), pc_redirect_sel=0; next state RUN; a new ex_redirect in this cycle is ignored.
REQ-022 Load-use hazard: ex_mem_read=1, ex_rd!=0, and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
REQ-023 On a load-use hazard: if_stall=id_stall=1, ex_flush=1 (one bubble); next state LOAD_STALL.
REQ-024 LOAD_STALL: no hazard compare, all outputs 0; next state RUN (exactly one bubble per load-use).
REQ-025 Redirect and load-use in the same cycle: redirect wins; no stall.
REQ-026 Mem-wait arising in REDIRECT or LOAD_STALL: the mem-wait outputs of REQ-018 override the state outputs; next state MEM_WAIT; the pending redirect or bubble is considered complete.
REQ-027 In RUN with no event, all outputs 0; hazards against x0 never stall.
REQ-028 stall_cycles increments on every cycle with if_stall=1 and holds at 0xFFFFFFFF; flush_events holds at 0xFFFF.

Reset
REQ-029 While resetn=0: state=INIT, counters=0, all stall outputs 0, id_flush=ex_flush=1, pc_redirect_sel=0.
REQ-030 Reset asserted mid-operation (any state) takes effect immediately and discards any pending bubble, redirect, or wait.

Structure
REQ-031 Package pipeline_ctrl_pkg holds the state enum, counter widths, and the NOP opcode constant.
REQ-032 The load-use comparator is a sub-module named hazard_detect (pure combinational, 1-bit hit output).

Verification
REQ-033 Reset release: INIT for 1 cycle (id_flush=ex_flush=1), then RUN with all outputs 0.
REQ-034 ex_mem_read=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 -> one cycle of if_stall=id_stall=ex_flush=1, then 0; stall_cycles=1. The same stimulus with ex_rd=0 -> no stall.
REQ-035 dmem_req=1 with ack after 3 cycles -> all stalls high for 3 cycles, low on the ack cycle; stall_cycles=3.
REQ-036 ex_redirect=1 together with a load-use hit -> pc_redirect_sel=id_flush=ex_flush=1, no stall; next cycle id_flush=1 only; flush_events=1.
REQ-037 ex_redirect=1 while dmem_req=1 and no ack for 2 cycles -> stalls only; on the ack cycle stalls drop; the next cycle performs the redirect flush.
REQ-038 Reset pulse during MEM_WAIT -> outputs immediately take their reset values; after release the INIT sequence repeats.
